// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and default geometry
package game_pkg;

  localparam int GAME_Y_W     = 9;
  localparam int GAME_Y_START = 240;
  localparam int GAME_Y_MAX   = 440;
  localparam int SPEED_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } state_t;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - 1-bit rising-edge detector, one cycle of history
module edge_rise (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_q <= 1'b0;
    else         r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - vertical ball motion engine (jump, gravity, landing)
// Optional gravity divider enabled by defining BALL_GRAVITY_DIV_EN.
module ball_motion
  import game_pkg::*;
#(
`ifdef BALL_GRAVITY_DIV_EN
  parameter int G_DIV   = 2,
`endif
  parameter int Y_W     = GAME_Y_W,
  parameter int Y_START = GAME_Y_START,
  parameter int Y_MAX   = GAME_Y_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic               jump,
  input  logic               collision,
  input  logic [SPEED_W-1:0] max_speed,
  output logic [SPEED_W-1:0] ball_speed,
  output logic               direction,
  output logic [Y_W-1:0]     ball_y,
  output logic               ground_hit,
  output logic               dead
);

  localparam logic [Y_W:0]         C_Y_MAX    = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0]       C_Y_START  = Y_W'(Y_START);
  localparam logic [SPEED_W-1:0]   C_VMAX_RST = SPEED_W'(7);

  state_t             r_state, w_state_nxt;
  logic [Y_W-1:0]     r_y, w_y_nxt, w_y_up, w_y_dn, w_speed_ext;
  logic [Y_W:0]       w_sum;
  logic [SPEED_W-1:0] r_speed, w_speed_nxt, r_vmax, w_vmax_nxt, w_speed_inc;
  logic               r_dir, w_dir_nxt, r_hit, w_hit_nxt, r_dead;
  logic               w_jump_edge, w_active, w_launch, w_move, w_land, w_apex, w_g_step;

  edge_rise u_jump_edge (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (jump),
    .o_rise  (w_jump_edge)
  );

  assign w_active    = (r_state == RISE) || (r_state == FALL);
  assign w_launch    = start && w_jump_edge && ((r_state == IDLE) || (w_active && !collision));
  assign w_move      = start && w_active && !collision && !w_jump_edge && tick;

  // Height math is one bit wider so the ceiling clamp sees the true sum.
  assign w_speed_ext = {{(Y_W-SPEED_W){1'b0}}, r_speed};
  assign w_sum       = {1'b0, r_y} + {1'b0, w_speed_ext};
  assign w_y_up      = (w_sum > C_Y_MAX) ? C_Y_MAX[Y_W-1:0] : w_sum[Y_W-1:0];
  assign w_y_dn      = r_y - w_speed_ext;
  assign w_land      = (r_y <= w_speed_ext);
  assign w_apex      = (r_speed == '0) || (w_g_step && (r_speed == SPEED_W'(1)));
  assign w_speed_inc = (r_speed < r_vmax) ? r_speed + SPEED_W'(1) : r_vmax;

`ifdef BALL_GRAVITY_DIV_EN
  localparam int G_W = (G_DIV > 1) ? $clog2(G_DIV) : 1;

  logic [G_W-1:0] r_g_cnt;

  assign w_g_step = (r_g_cnt == G_W'(G_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || w_launch || (w_state_nxt != r_state))
      r_g_cnt <= '0;
    else if (w_move)
      r_g_cnt <= w_g_step ? '0 : r_g_cnt + G_W'(1);
  end
`else
  assign w_g_step = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!start) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_jump_edge) w_state_nxt = RISE;
        RISE: begin
          if (collision)             w_state_nxt = DEAD;
          else if (w_jump_edge)      w_state_nxt = RISE;
          else if (tick && w_apex)   w_state_nxt = FALL;
        end
        FALL: begin
          if (collision)             w_state_nxt = DEAD;
          else if (w_jump_edge)      w_state_nxt = RISE;
          else if (tick && w_land)   w_state_nxt = DEAD;
        end
        DEAD:    w_state_nxt = DEAD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_y_nxt     = r_y;
    w_speed_nxt = r_speed;
    w_dir_nxt   = r_dir;
    w_vmax_nxt  = r_vmax;
    w_hit_nxt   = 1'b0;
    if (!start || (r_state == IDLE)) begin
      w_y_nxt     = C_Y_START;
      w_speed_nxt = '0;
      w_dir_nxt   = 1'b0;
    end
    if (w_launch) begin
      w_speed_nxt = max_speed;
      w_dir_nxt   = 1'b1;
      w_vmax_nxt  = max_speed;
    end else if (w_move) begin
      if (r_state == RISE) begin
        w_y_nxt = w_y_up;
        if (w_apex) begin
          w_speed_nxt = '0;
          w_dir_nxt   = 1'b0;
        end else if (w_g_step) begin
          w_speed_nxt = r_speed - SPEED_W'(1);
        end
      end else if (w_land) begin
        w_y_nxt   = '0;
        w_hit_nxt = 1'b1;
      end else begin
        w_y_nxt = w_y_dn;
        if (w_g_step) w_speed_nxt = w_speed_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y     <= C_Y_START;
      r_speed <= '0;
      r_dir   <= 1'b0;
      r_vmax  <= C_VMAX_RST;
      r_hit   <= 1'b0;
      r_dead  <= 1'b0;
    end else begin
      r_y     <= w_y_nxt;
      r_speed <= w_speed_nxt;
      r_dir   <= w_dir_nxt;
      r_vmax  <= w_vmax_nxt;
      r_hit   <= w_hit_nxt;
      r_dead  <= (w_state_nxt == DEAD);
    end
  end

  assign ball_y     = r_y;
  assign ball_speed = r_speed;
  assign direction  = r_dir;
  assign ground_hit = r_hit;
  assign dead       = r_dead;

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - directed self-checking bench for ball_motion
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset, start, tick, jump, collision;
  logic [3:0] max_speed;
  logic [3:0] ball_speed;
  logic       direction;
  logic [8:0] ball_y;
  logic       ground_hit, dead;

  int n_checks = 0;
  int n_fail   = 0;
  int hit_cnt  = 0;
  int ey, es, h0, landed;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .jump       (jump),
    .collision  (collision),
    .max_speed  (max_speed),
    .ball_speed (ball_speed),
    .direction  (direction),
    .ball_y     (ball_y),
    .ground_hit (ground_hit),
    .dead       (dead)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (ground_hit === 1'b1) hit_cnt++;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic press(input logic [3:0] ms);
    max_speed = ms;
    jump = 1'b1;
    step();
    jump = 1'b0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; jump = 1'b0; collision = 1'b0; max_speed = 4'd7;
    step();
    step();
    check("rst_y", ball_y, 240);
    check("rst_speed", ball_speed, 0);
    check("rst_dir", direction, 0);
    check("rst_hit", ground_hit, 0);
    check("rst_dead", dead, 0);
    reset = 1'b0;
    start = 1'b1;
    step();

`ifdef BALL_GRAVITY_DIV_EN
    press(4'd4);
    check("g_launch_speed", ball_speed, 4);
    ey = 240; es = 4;
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      ey += es;
      if (i % 2 == 0) es--;
      check("g_rise_y", ball_y, ey);
      check("g_rise_speed", ball_speed, es);
    end
    check("g_apex_y", ball_y, 260);
    check("g_apex_dir", direction, 0);
`else
    // Launch and rise to the apex
    press(4'd7);
    check("launch_speed", ball_speed, 7);
    check("launch_dir", direction, 1);
    check("launch_y", ball_y, 240);
    ey = 240; es = 7;
    for (int i = 0; i < 7; i++) begin
      do_tick();
      ey += es;
      es--;
      check("rise_y", ball_y, ey);
      check("rise_speed", ball_speed, es);
    end
    check("apex_y", ball_y, 268);
    check("apex_dir", direction, 0);

    // Fall to the ground
    h0 = hit_cnt;
    landed = 0;
    for (int i = 0; i < 60 && landed == 0; i++) begin
      do_tick();
      if (ey <= es) begin
        ey = 0;
        landed = 1;
      end else begin
        ey -= es;
        if (es < 7) es++;
      end
      check("fall_y", ball_y, ey);
      check("fall_speed", ball_speed, es);
    end
    check("fall_landed", landed, 1);
    check("land_hits", hit_cnt - h0, 1);
    check("land_dead", dead, 1);
    check("land_y", ball_y, 0);

    // DEAD ignores jumps and ticks
    press(4'd5);
    do_tick();
    check("dead_frozen_dead", dead, 1);
    check("dead_frozen_speed", ball_speed, 7);
    check("dead_frozen_y", ball_y, 0);
    check("dead_frozen_dir", direction, 0);
    check("dead_no_rehit", hit_cnt - h0, 1);

    // start low returns to IDLE
    start = 1'b0;
    step();
    check("idle_y", ball_y, 240);
    check("idle_speed", ball_speed, 0);
    check("idle_dead", dead, 0);
    start = 1'b1;
    step();

    // Held jump during FALL gives one relaunch
    press(4'd7);
    for (int i = 0; i < 9; i++) do_tick();
    check("fall2_y", ball_y, 267);
    check("fall2_speed", ball_speed, 2);
    jump = 1'b1;
    step();
    check("hold_speed", ball_speed, 7);
    check("hold_dir", direction, 1);
    check("hold_y", ball_y, 267);
    repeat (13) step();
    for (int i = 0; i < 3; i++) do_tick();
    check("hold_rise_y", ball_y, 285);
    check("hold_rise_speed", ball_speed, 4);
    jump = 1'b0;
    step();

    // Collision beats a simultaneous jump edge
    h0 = hit_cnt;
    jump = 1'b1;
    collision = 1'b1;
    step();
    jump = 1'b0;
    collision = 1'b0;
    check("coll_dead", dead, 1);
    check("coll_speed", ball_speed, 4);
    check("coll_y", ball_y, 285);
    do_tick();
    check("coll_frozen_y", ball_y, 285);
    check("coll_no_hit", hit_cnt - h0, 0);

    // Climb near the ceiling with repeated relaunches, then saturate
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    for (int i = 0; i < 19; i++) begin
      press(4'd10);
      do_tick();
    end
    check("climb_y", ball_y, 430);
    press(4'd9);
    ey = 430; es = 9;
    for (int i = 0; i < 9; i++) begin
      do_tick();
      ey = (ey + es > 440) ? 440 : ey + es;
      es--;
      check("sat_y", ball_y, ey);
    end
    check("sat_speed", ball_speed, 0);
    check("sat_dir", direction, 0);

    // Zero launch speed flips straight to FALL and stays at speed 0
    press(4'd0);
    check("zero_speed", ball_speed, 0);
    check("zero_dir", direction, 1);
    do_tick();
    check("zero_flip_dir", direction, 0);
    check("zero_flip_y", ball_y, 440);
    do_tick();
    check("zero_fall_y", ball_y, 440);
    check("zero_fall_speed", ball_speed, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Vertical motion engine for the player ball.
- Consumes `max_speed` from the speed-adaptation logic and produces the `ball_speed` and `direction` values that logic samples. It closes the loop: `ball_speed==0 && direction==0` marks the apex.
- Integrates ball height once per frame tick, handles jump presses, and raises `ground_hit` when the ball lands.
- Sits between the button debouncer / frame timer and the renderer / collision checker.

Parameters:
- `Y_W`, 9: ball height width in pixels.
- `Y_START`, 240: height loaded on reset and while idle.
- `Y_MAX`, 440: ceiling; height saturates here.
- `G_DIV`, 2: gravity divider. Only used when `BALL_GRAVITY_DIV_EN` is defined.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: game running. Low forces IDLE.
- `tick`, in, 1: one-cycle frame strobe.
- `jump`, in, 1: debounced jump button, level.
- `collision`, in, 1: barrier hit from the collision checker.
- `max_speed`, in, 4: launch speed and terminal speed.
- `ball_speed`, out, 4: current speed magnitude.
- `direction`, out, 1: 1 = rising, 0 = falling.
- `ball_y`, out, `Y_W`: current height, 0 = ground.
- `ground_hit`, out, 1: one-cycle pulse on landing.
- `dead`, out, 1: high in DEAD state.

Behaviour:
- Reset (sync, active-high) values:
  - state = IDLE, `ball_y` = `Y_START`, `ball_speed` = 0, `direction` = 0.
  - `ground_hit` = 0, `dead` = 0, `jump` edge register = 0, `vmax` = 7.
- Jump detection: rising edge of `jump`, i.e. `jump & ~jump_q`, registered every cycle. Holding the button gives one jump only.
- Launch: on a jump edge, `vmax` latches `max_speed`. This latched value is used as both launch speed and terminal speed until the next jump.
- States:
  - IDLE:
    - Outputs held at their reset values.
    - `start=1` with a jump edge → RISE, `ball_speed` = `max_speed`, `direction` = 1.
  - RISE, on `tick`:
    - `ball_y` += `ball_speed`, saturating at `Y_MAX`.
    - `ball_speed` -= 1.
    - When the new `ball_speed` is 0: `direction` = 0, state → FALL. The apex value (speed 0, direction 0) is visible for at least one full tick period.
  - FALL, on `tick`:
    - If `ball_y` ≤ `ball_speed`: `ball_y` = 0, `ground_hit` pulses 1 cycle, state → DEAD.
    - Otherwise `ball_y` -= `ball_speed`, then `ball_speed` = min(`ball_speed`+1, `vmax`).
  - DEAD:
    - `dead` = 1; `ball_y`, `ball_speed` and `direction` are frozen.
    - Leaves only via `reset` or `start=0` → IDLE.
- Jump edge in RISE or FALL: relaunch, `ball_speed` = `max_speed`, `direction` = 1, state → RISE.
- Priorities when events coincide, same cycle:
  1. `reset`.
  2. `start=0` → IDLE.
  3. `collision=1` → DEAD, no `ground_hit` pulse.
  4. Jump edge. A jump edge coinciding with `tick` performs the relaunch only; there is no position update in that cycle.
  5. `tick` motion update.
- `max_speed=0` at jump: the ball enters RISE with speed 0. On the first tick it flips to FALL with `ball_y` unchanged.
- Arithmetic: height is computed in `Y_W+1` bits before saturation; no wrap-around is permitted at 0 or `Y_MAX`.
- Latency: all outputs are registered, one cycle after the causing input.

Optional Feature:
- `BALL_GRAVITY_DIV_EN`:
  - Defined: a gravity counter (width ceil(log2(`G_DIV`))) counts ticks. `ball_speed` changes only on every `G_DIV`-th tick in RISE and FALL; position still moves every tick. The counter clears on jump, reset and state change.
  - Undefined: the speed changes every tick and no counter is instantiated.

Decomposition:
- Shared package `game_pkg` holds:
  - the state enum (IDLE, RISE, FALL, DEAD);
  - the `Y_W`, `Y_START` and `Y_MAX` defaults;
  - the speed width constant (4), shared with the speed-adaptation and barrier logic.
- One sub-module, `edge_rise`: 1-bit registered rising-edge detector with sync reset. It is used for `jump` and is reusable for the other buttons.

Test Plan:
- Reset, `start=1`, jump edge with `max_speed=7`, then 7 ticks → `ball_y` = 240+7+6+5+4+3+2+1 = 268; `ball_speed`=0, `direction`=0, state FALL.
- Continue the falling ticks from `ball_y`=268 with `max_speed` held at 7 → speeds 0,1,2,…,7 then stay at 7; `ground_hit` pulses exactly once when `ball_y` reaches 0; `dead`=1.
- Jump held high for 20 cycles during FALL → exactly one relaunch; `ball_speed`=`max_speed` the next cycle.
- `collision=1` and a jump edge in the same cycle → DEAD, no relaunch, `ground_hit` stays 0.
- `max_speed=9` at jump, starting from `ball_y`=430 → `ball_y` saturates at 440, never wraps.
- With `BALL_GRAVITY_DIV_EN` and `G_DIV=2`: `max_speed=4` jump → speeds 4,4,3,3,2,2,1,1,0 per tick; apex height 240+20 = 260.
